cpa_row_resolver: RTL
=====================

# cpa_row_resolver

Sequential carry-propagate adder that sits after the 7:2 compressor reduction tree of the 16-bit approximate multiplier. It accepts the two rows the tree produces, the sum row and the carry row. It resolves them into the final WIDTH-bit product, working CHUNK bits per cycle, and uses valid/ready handshakes on both sides. It replaces a wide single-cycle ripple adder to shorten the critical path.

## Interface
- WIDTH, 32: width of each row and of the result (2×16-bit multiplier).
- CHUNK, 8: bits resolved per cycle; WIDTH must be an integer multiple of CHUNK.
- clk  input  1  sole clock, rising edge.
- rst  input  1  reset; synchronous, active-high.
- in_valid  input  1  upstream has a row pair.
- in_ready  output  1  block can accept a row pair.
- in_sum  input  WIDTH  sum row from the compressor tree.
- in_carry  input  WIDTH  carry row, already weight-aligned by the tree (no internal shift).
- out_valid  output  1  result available.
- out_ready  input  1  downstream accepts the result.
- out_result  output  WIDTH  (in_sum + in_carry) mod 2^WIDTH.
- out_cout  output  1  carry out of bit WIDTH-1.

## Operation
- N = WIDTH/CHUNK chunk steps. States: IDLE, ADD, DONE.
- IDLE:
  - in_ready=1.
  - On in_valid && in_ready: latch in_sum and in_carry, clear the running carry, set idx=0, clear the result register, go to ADD.
- ADD:
  - in_ready=0.
  - Each cycle, result[idx*CHUNK +: CHUNK] = sum_chunk + carry_chunk + c.
  - The chunk carry-out becomes c for the next step; idx increments.
  - On the step with idx=N-1, store c into out_cout and go to DONE.
- DONE:
  - out_valid=1.
  - out_result and out_cout are held stable until out_valid && out_ready, then the block goes to IDLE.
  - in_ready=0 in DONE; there is no overlap of output and input handshakes.
- Arithmetic is unsigned and modulo 2^WIDTH. The chunk adder is exact; approximation lives only upstream.
- Inputs are sampled only at the accept edge. Changes to in_sum and in_carry afterwards have no effect.
- in_valid while busy is ignored, not dropped: upstream must hold in_valid until in_ready.
- out_ready while not in DONE is ignored.
- Reset mid-operation aborts the addition. No out_valid is produced for the aborted pair.

## Timing
- Reset values after the rst edge:
  - state=IDLE, in_ready=1, out_valid=0
  - out_result=0, out_cout=0
  - idx=0, running carry=0
- Latency: with the accept on edge k, out_valid rises after edge k+N (N ADD cycles).
- Minimum initiation interval: N+2 cycles (N ADD, 1 DONE with immediate out_ready, 1 IDLE).
- in_ready and out_valid decode directly from the state register, with no combinational path from in_valid or out_ready.
- out_result shows partial chunks during ADD. It is meaningful only while out_valid=1.
- N=1 (CHUNK=WIDTH) is legal: one ADD cycle, then DONE.

## Structure
- Shared package cpa_pkg:
  - state enum {IDLE, ADD, DONE}
  - function computing N and the idx width $clog2(N), minimum 1 bit
  - elaboration check that WIDTH % CHUNK == 0
- Sub-module cpa_chunk:
  - combinational CHUNK-bit adder with inputs a, b, cin and outputs s, cout
  - one instance, fed by muxed chunk slices selected by idx
- Top level holds the FSM, operand registers, idx counter, running carry and result register.

## Test plan
- WIDTH=32, CHUNK=8, sum=0x0000_00FF, carry=0x0000_0001 → result 0x0000_0100, cout=0, out_valid exactly 4 cycles after the accept edge.
- sum=0xFFFF_FFFF, carry=0x0000_0001 → result 0x0000_0000, cout=1; the carry ripples across all 4 chunks.
- Backpressure: sum=0x1234_5678, carry=0x1111_1111, out_ready low for 10 cycles → out_valid held, out_result=0x2345_6789 stable, in_ready=0 throughout; the handshake then returns to IDLE.
- Reset at idx=2 during ADD → next cycle in_ready=1, out_valid=0, out_result=0, out_cout=0. The following op 0x8000_0000+0x8000_0000 gives result 0, cout=1.
- Back-to-back, with in_valid held high and out_ready=1 → the second pair is accepted exactly one cycle after the first output handshake; the measured interval between out_valid pulses is 6 cycles.
- Random: 10k vectors checked against a 33-bit model, run at CHUNK=8, CHUNK=4 and CHUNK=32 (N=1), with random in_valid/out_ready stalls.

Source files
------------

// File: rtl/cpa_row_resolver_pkg.sv
// cpa_pkg: shared FSM state type and chunk-count / index-width helpers for cpa_row_resolver
package cpa_pkg;
  typedef enum logic [1:0] {IDLE, ADD, DONE} state_t;
  function automatic int num_chunks(input int width, input int chunk);
    return width / chunk;
  endfunction
  function automatic int idx_width(input int n);
    return n <= 1 ? 1 : $clog2(n);
  endfunction
endpackage

// File: rtl/cpa_row_resolver_if.sv
// cpa_row_resolver_if: in_valid/in_ready/in_sum/in_carry request side and out_valid/out_ready/out_result/out_cout response side
interface cpa_row_resolver_if #(parameter int WIDTH = 32);
  logic in_valid;
  logic in_ready;
  logic [WIDTH-1:0] in_sum;
  logic [WIDTH-1:0] in_carry;
  logic out_valid;
  logic out_ready;
  logic [WIDTH-1:0] out_result;
  logic out_cout;
  modport master (output in_valid, in_sum, in_carry, out_ready, input in_ready, out_valid, out_result, out_cout);
  modport slave (input in_valid, in_sum, in_carry, out_ready, output in_ready, out_valid, out_result, out_cout);
endinterface

// File: rtl/cpa_row_resolver_chunk.sv
// cpa_chunk: combinational CHUNK-bit adder, ports a/b/cin in, s/cout out
module cpa_chunk #(parameter int CHUNK = 8) (
  input  logic [CHUNK-1:0] a,
  input  logic [CHUNK-1:0] b,
  input  logic             cin,
  output logic [CHUNK-1:0] s,
  output logic             cout
);
  assign {cout, s} = {1'b0, a} + {1'b0, b} + {{CHUNK{1'b0}}, cin};
endmodule

// File: rtl/cpa_row_resolver.sv
// cpa_row_resolver: resolves sum/carry rows into WIDTH-bit result CHUNK bits per cycle; ports clk, rst, bus (slave)
module cpa_row_resolver
  import cpa_pkg::*;
#(
  parameter int WIDTH = 32,
  parameter int CHUNK = 8
) (
  input logic clk,
  input logic rst,
  cpa_row_resolver_if.slave bus
);
  localparam int N = num_chunks(WIDTH, CHUNK);
  localparam int IW = idx_width(N);
  if (WIDTH % CHUNK != 0) begin : g_bad_chunk
    $error("WIDTH must be a multiple of CHUNK");
  end
  state_t state, state_nx;
  logic [WIDTH-1:0] sum_q, carry_q, result_q;
  logic [IW-1:0] idx;
  logic c, cout_q, co, last;
  logic [CHUNK-1:0] s;
  assign last = idx == IW'(N - 1);
  cpa_chunk #(.CHUNK(CHUNK)) u_chunk (
    .a(sum_q[idx*CHUNK +: CHUNK]),
    .b(carry_q[idx*CHUNK +: CHUNK]),
    .cin(c),
    .s(s),
    .cout(co)
  );
  always_ff @(posedge clk) begin
    if (rst) begin
      state <= IDLE;
      sum_q <= '0;
      carry_q <= '0;
      result_q <= '0;
      idx <= '0;
      c <= 1'b0;
      cout_q <= 1'b0;
    end else begin
      state <= state_nx;
      if (state == IDLE && bus.in_valid) begin
        sum_q <= bus.in_sum;
        carry_q <= bus.in_carry;
        result_q <= '0;
        idx <= '0;
        c <= 1'b0;
      end else if (state == ADD) begin
        result_q[idx*CHUNK +: CHUNK] <= s;
        c <= co;
        idx <= last ? '0 : idx + 1'b1;
        if (last) cout_q <= co;
      end
    end
  end
  always_comb begin
    state_nx = state == IDLE ? (bus.in_valid ? ADD : IDLE)
             : state == ADD  ? (last ? DONE : ADD)
             : (bus.out_ready ? IDLE : DONE);
  end
  always_comb begin
    bus.in_ready = state == IDLE;
    bus.out_valid = state == DONE;
  end
  assign bus.out_result = result_q;
  assign bus.out_cout = cout_q;
endmodule
